// File: rtl/fx_divider_pkg.sv
// Shared constants and state encoding for the iterative restoring fixed-point divider.
package fx_divider_pkg;

   localparam int NW   = 16;
   localparam int DW   = 16;
   localparam int QW   = 24;
   localparam int SMAX = 16;
   localparam int ITER = NW + SMAX;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/fx_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits and report the resulting quotient bit.
module fx_div_step
   import fx_divider_pkg::*;
(
   input  logic [DW:0]   r,
   input  logic          bit_in,
   input  logic [DW-1:0] d,
   output logic [DW:0]   r_next,
   output logic          q
);

   logic [DW+1:0] shifted;
   logic [DW+1:0] d_ext;

   // One extra bit on the shifted remainder so the compare never wraps.
   assign shifted = {r, bit_in};
   assign d_ext   = {2'b00, d};
   assign q       = (shifted >= d_ext);
   assign r_next  = q ? (DW+1)'(shifted - d_ext) : (DW+1)'(shifted);

endmodule

// File: rtl/fx_divider.sv
// Iterative fixed-point divider coprocessor: Quotient = floor((Numer << Shift) / Denom),
// one quotient bit per clock, with divide-by-zero and overflow saturation.
module fx_divider
   import fx_divider_pkg::*;
(
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Go,
   input  logic [NW-1:0] Numer,
   input  logic [DW-1:0] Denom,
   input  logic [4:0]    Shift,
   output logic          Busy,
   output logic          Valid,
   output logic [QW-1:0] Quotient,
   output logic          DivZero,
   output logic          Ovf
);

   state_t          state;
   logic [ITER-1:0] x_reg;
   logic [ITER-1:0] q_acc;
   logic [DW-1:0]   d_reg;
   logic [DW:0]     r_reg;
   logic [DW:0]     r_next;
   logic [CW-1:0]   cnt;
   logic            q_bit;
   logic [4:0]      shift_c;

   assign shift_c = (Shift > 5'(SMAX)) ? 5'(SMAX) : Shift;

   fx_div_step u_step (
      .r      (r_reg),
      .bit_in (x_reg[ITER-1]),
      .d      (d_reg),
      .r_next (r_next),
      .q      (q_bit)
   );

   // Results are published on leaving FIN, so they only move when Valid pulses.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         x_reg    <= '0;
         q_acc    <= '0;
         d_reg    <= '0;
         r_reg    <= '0;
         cnt      <= '0;
         Busy     <= 1'b0;
         Valid    <= 1'b0;
         Quotient <= '0;
         DivZero  <= 1'b0;
         Ovf      <= 1'b0;
      end else begin
         Valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Go) begin
                  x_reg <= ITER'(Numer) << shift_c;
                  d_reg <= Denom;
                  r_reg <= '0;
                  q_acc <= '0;
                  cnt   <= '0;
                  Busy  <= 1'b1;
                  state <= (Denom == '0) ? FIN : RUN;
               end
            end
            RUN: begin
               x_reg <= {x_reg[ITER-2:0], 1'b0};
               r_reg <= r_next;
               q_acc <= {q_acc[ITER-2:0], q_bit};
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(ITER - 1)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               Busy  <= 1'b0;
               Valid <= 1'b1;
               state <= IDLE;
               if (d_reg == '0) begin
                  Quotient <= '1;
                  DivZero  <= 1'b1;
                  Ovf      <= 1'b0;
               end else if (|q_acc[ITER-1:QW]) begin
                  Quotient <= '1;
                  DivZero  <= 1'b0;
                  Ovf      <= 1'b1;
               end else begin
                  Quotient <= q_acc[QW-1:0];
                  DivZero  <= 1'b0;
                  Ovf      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fx_divider.sv
// Self-checking bench for fx_divider: directed cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_fx_divider;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Go;
   logic [15:0] Numer;
   logic [15:0] Denom;
   logic [4:0]  Shift;
   logic        Busy;
   logic        Valid;
   logic [23:0] Quotient;
   logic        DivZero;
   logic        Ovf;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [23:0] last_q   = '0;

   logic [15:0] tn  [5] = '{16'h0001, 16'h0003, 16'hFFFF, 16'hFFFF, 16'hFFFF};
   logic [15:0] td  [5] = '{16'h0004, 16'h00FF, 16'h00FF, 16'h0001, 16'h0001};
   logic [4:0]  ts  [5] = '{5'd15, 5'd8, 5'd8, 5'd16, 5'd31};
   logic [23:0] tq  [5] = '{24'h002000, 24'h000003, 24'h010100, 24'hFFFFFF, 24'hFFFFFF};
   logic        tov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   fx_divider dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Go       (Go),
      .Numer    (Numer),
      .Denom    (Denom),
      .Shift    (Shift),
      .Busy     (Busy),
      .Valid    (Valid),
      .Quotient (Quotient),
      .DivZero  (DivZero),
      .Ovf      (Ovf)
   );

   always #5 Clk = ~Clk;

   // Reference: exact integer division of the aligned numerator, then saturate.
   function automatic void model(input logic [15:0] n, input logic [15:0] d, input logic [4:0] s,
                                 output logic [23:0] q, output logic dz, output logic ov);
      int unsigned     sc;
      longint unsigned x;
      longint unsigned full;
      sc = (s > 5'd16) ? 16 : int'(s);
      x  = longint'(n) << sc;
      dz = 1'b0;
      ov = 1'b0;
      if (d == 16'd0) begin
         q  = 24'hFFFFFF;
         dz = 1'b1;
      end else begin
         full = x / longint'(d);
         if (full > 64'hFFFFFF) begin
            q  = 24'hFFFFFF;
            ov = 1'b1;
         end else begin
            q = full[23:0];
         end
      end
   endfunction

   // Pulse Go for one rising edge; returns at the falling edge after that edge.
   task automatic applyStimulus(input logic [15:0] n, input logic [15:0] d, input logic [4:0] s);
      @(negedge Clk);
      Numer = n;
      Denom = d;
      Shift = s;
      Go    = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
   endtask

   task automatic wait_valid(input int start, input int limit, output int cyc);
      cyc = start;
      while (Valid !== 1'b1 && cyc < limit) begin
         @(negedge Clk);
         cyc++;
      end
      if (Valid !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Go    = 1'b1;
      Numer = 16'h0005;
      Denom = 16'h0000;
      Shift = 5'd0;
      repeat (3) @(negedge Clk);
      n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", Busy); else n_pass++;
      n_checks++; if (Valid !== 1'b0) $display("[TB] FAIL reset_valid got %b expected 0", Valid); else n_pass++;
      n_checks++; if (Quotient !== 24'h0) $display("[TB] FAIL reset_quotient got %h expected 000000", Quotient); else n_pass++;
      n_checks++; if (DivZero !== 1'b0) $display("[TB] FAIL reset_divzero got %b expected 0", DivZero); else n_pass++;
      n_checks++; if (Ovf !== 1'b0) $display("[TB] FAIL reset_ovf got %b expected 0", Ovf); else n_pass++;
      Reset = 1'b0;
      Go    = 1'b0;
      @(negedge Clk);
      n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL reset_go_busy got %b expected 0", Busy); else n_pass++;
      n_checks++; if (Valid !== 1'b0) $display("[TB] FAIL reset_go_valid got %b expected 0", Valid); else n_pass++;
      last_q = 24'h0;
   endtask

   task automatic test_directed();
      int          cyc;
      logic [23:0] mq;
      logic        mdz, mov;
      for (int i = 0; i < 5; i++) begin
         model(tn[i], td[i], ts[i], mq, mdz, mov);
         applyStimulus(tn[i], td[i], ts[i]);
         wait_valid(0, 60, cyc);
         n_checks++; if (cyc != 33) $display("[TB] FAIL dir%0d_latency got %0d expected 33", i, cyc); else n_pass++;
         n_checks++; if (Quotient !== tq[i]) $display("[TB] FAIL dir%0d_quotient got %h expected %h", i, Quotient, tq[i]); else n_pass++;
         n_checks++; if (Quotient !== mq) $display("[TB] FAIL dir%0d_model got %h expected %h", i, Quotient, mq); else n_pass++;
         n_checks++; if (Ovf !== tov[i]) $display("[TB] FAIL dir%0d_ovf got %b expected %b", i, Ovf, tov[i]); else n_pass++;
         n_checks++; if (DivZero !== 1'b0) $display("[TB] FAIL dir%0d_divzero got %b expected 0", i, DivZero); else n_pass++;
         @(negedge Clk);
         n_checks++; if (Valid !== 1'b0) $display("[TB] FAIL dir%0d_pulse got %b expected 0", i, Valid); else n_pass++;
         last_q = tq[i];
      end
   endtask

   task automatic test_div_zero();
      int cyc;
      applyStimulus(16'h1234, 16'h0000, 5'd3);
      n_checks++; if (Busy !== 1'b1) $display("[TB] FAIL dz_busy_high got %b expected 1", Busy); else n_pass++;
      wait_valid(0, 10, cyc);
      n_checks++; if (cyc != 1) $display("[TB] FAIL dz_latency got %0d expected 1", cyc); else n_pass++;
      n_checks++; if (Quotient !== 24'hFFFFFF) $display("[TB] FAIL dz_quotient got %h expected ffffff", Quotient); else n_pass++;
      n_checks++; if (DivZero !== 1'b1) $display("[TB] FAIL dz_flag got %b expected 1", DivZero); else n_pass++;
      n_checks++; if (Ovf !== 1'b0) $display("[TB] FAIL dz_ovf got %b expected 0", Ovf); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL dz_busy_low got %b expected 0", Busy); else n_pass++;
      last_q = 24'hFFFFFF;
   endtask

   task automatic test_go_while_busy();
      int          cyc;
      logic [23:0] prev;
      bit          stable_ok;
      prev      = last_q;
      stable_ok = 1'b1;
      applyStimulus(16'h0007, 16'h0002, 5'd0);
      for (int c = 1; c < 10; c++) begin
         if (Quotient !== prev) stable_ok = 1'b0;
         @(negedge Clk);
      end
      Numer = 16'h0064;
      Denom = 16'h0003;
      Shift = 5'd5;
      Go    = 1'b1;
      @(negedge Clk);
      Go  = 1'b0;
      cyc = 10;
      while (Valid !== 1'b1 && cyc < 60) begin
         if (Quotient !== prev) stable_ok = 1'b0;
         @(negedge Clk);
         cyc++;
      end
      if (Valid !== 1'b1) cyc = -1;
      n_checks++; if (cyc != 33) $display("[TB] FAIL busy_go_latency got %0d expected 33", cyc); else n_pass++;
      n_checks++; if (Quotient !== 24'h000003) $display("[TB] FAIL busy_go_quotient got %h expected 000003", Quotient); else n_pass++;
      n_checks++; if (stable_ok !== 1'b1) $display("[TB] FAIL busy_q_stable got %b expected 1", stable_ok); else n_pass++;
      @(negedge Clk);
      n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL busy_go_idle got %b expected 0", Busy); else n_pass++;
      last_q = 24'h000003;
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit seen;
      applyStimulus(16'hABCD, 16'h0007, 5'd4);
      repeat (11) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL mid_reset_busy got %b expected 0", Busy); else n_pass++;
      n_checks++; if (Quotient !== 24'h0) $display("[TB] FAIL mid_reset_quotient got %h expected 000000", Quotient); else n_pass++;
      n_checks++; if (Valid !== 1'b0) $display("[TB] FAIL mid_reset_valid got %b expected 0", Valid); else n_pass++;
      seen = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         if (Valid === 1'b1) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) $display("[TB] FAIL mid_reset_no_valid got %b expected 0", seen); else n_pass++;
      applyStimulus(16'h000A, 16'h0003, 5'd0);
      wait_valid(0, 60, cyc);
      n_checks++; if (cyc != 33) $display("[TB] FAIL after_reset_latency got %0d expected 33", cyc); else n_pass++;
      n_checks++; if (Quotient !== 24'h000003) $display("[TB] FAIL after_reset_quotient got %h expected 000003", Quotient); else n_pass++;
      last_q = 24'h000003;
   endtask

   task automatic test_back_to_back();
      int          cyc;
      logic [23:0] q1, q2;
      logic        dz1, ov1, dz2, ov2;
      model(16'h0100, 16'h0003, 5'd4, q1, dz1, ov1);
      model(16'h8000, 16'h00FF, 5'd16, q2, dz2, ov2);
      @(negedge Clk);
      Numer = 16'h0100;
      Denom = 16'h0003;
      Shift = 5'd4;
      Go    = 1'b1;
      @(negedge Clk);
      Numer = 16'h8000;
      Denom = 16'h00FF;
      Shift = 5'd16;
      wait_valid(0, 60, cyc);
      n_checks++; if (cyc != 33) $display("[TB] FAIL b2b_first_latency got %0d expected 33", cyc); else n_pass++;
      n_checks++; if (Quotient !== q1) $display("[TB] FAIL b2b_first_quotient got %h expected %h", Quotient, q1); else n_pass++;
      @(negedge Clk);
      n_checks++; if (Busy !== 1'b1) $display("[TB] FAIL b2b_restart_busy got %b expected 1", Busy); else n_pass++;
      wait_valid(34, 100, cyc);
      Go = 1'b0;
      n_checks++; if (cyc != 67) $display("[TB] FAIL b2b_second_latency got %0d expected 67", cyc); else n_pass++;
      n_checks++; if (Quotient !== q2) $display("[TB] FAIL b2b_second_quotient got %h expected %h", Quotient, q2); else n_pass++;
      @(negedge Clk);
      n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL b2b_stop_busy got %b expected 0", Busy); else n_pass++;
      last_q = q2;
   endtask

   task automatic test_random();
      int          cyc, exp_lat;
      logic [15:0] n, d;
      logic [4:0]  s;
      logic [23:0] mq;
      logic        mdz, mov;
      for (int i = 0; i < 24; i++) begin
         n = 16'($urandom);
         s = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       d = 16'($urandom_range(1, 255));
            1:       d = 16'($urandom);
            2:       d = 16'($urandom_range(0, 3));
            default: d = 16'($urandom_range(256, 65535));
         endcase
         model(n, d, s, mq, mdz, mov);
         exp_lat = (d == 16'd0) ? 1 : 33;
         applyStimulus(n, d, s);
         wait_valid(0, 60, cyc);
         n_checks++; if (cyc != exp_lat) $display("[TB] FAIL rnd%0d_latency got %0d expected %0d", i, cyc, exp_lat); else n_pass++;
         n_checks++; if (Quotient !== mq) $display("[TB] FAIL rnd%0d_quotient n=%h d=%h s=%0d got %h expected %h", i, n, d, s, Quotient, mq); else n_pass++;
         n_checks++; if (DivZero !== mdz) $display("[TB] FAIL rnd%0d_divzero got %b expected %b", i, DivZero, mdz); else n_pass++;
         n_checks++; if (Ovf !== mov) $display("[TB] FAIL rnd%0d_ovf got %b expected %b", i, Ovf, mov); else n_pass++;
         last_q = mq;
      end
   endtask

   initial begin
      Reset = 1'b1;
      Go    = 1'b0;
      Numer = '0;
      Denom = '0;
      Shift = '0;
      test_reset();
      test_directed();
      test_div_zero();
      test_go_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fx_divider.md
Name: fx_divider

Overview:
- Iterative restoring fixed-point divider. It is a coprocessor attached to the CPU datapath, alongside data memory DM1.
- It computes Q = floor((N << S) / D), one quotient bit per clock. The reciprocal program uses N=1, S=15, 16-bit result; the 16/8 divide program uses S=8, 24-bit result.
- The CPU issues an operation, stalls on Busy, and stores Quotient bytes to DM1 once Valid pulses.

Parameters:
- NW, 16, numerator width.
- DW, 16, divisor width; 8-bit divisors are zero-extended by the CPU.
- QW, 24, result width.
- SMAX, 16, maximum left shift; iteration count is NW+SMAX.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Go  in  1  start request; sampled only in IDLE.
- Numer  in  NW  dividend N, unsigned.
- Denom  in  DW  divisor D, unsigned.
- Shift  in  5  fraction shift S; values above SMAX are clamped to SMAX.
- Busy  out  1  high while an operation is in progress.
- Valid  out  1  one-cycle pulse when Quotient is final.
- Quotient  out  QW  result; held until next accepted Go.
- DivZero  out  1  set with Valid when D==0; held like Quotient.
- Ovf  out  1  set with Valid when the true quotient ≥ 2^QW; held like Quotient.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs, including mid-operation):
  - state=IDLE.
  - Busy=0, Valid=0, Quotient=0, DivZero=0, Ovf=0.
  - Iteration counter and partial remainder cleared.
  - An in-flight operation is discarded with no Valid.
- States:
  - IDLE: on Go=1, latch Numer, Denom and clamped Shift; go to RUN (D!=0) or FIN (D==0). Busy=1 from the next cycle.
  - RUN: count K = NW+SMAX iterations (32 by default).
  - FIN: one cycle; Valid=1, Busy=0, outputs updated; next state IDLE.
- Operand alignment: numerator register X = N << S, zero-extended to NW+SMAX bits (32).
- RUN iteration (MSB first):
  - R = (R<<1) | next X bit.
  - If R ≥ D: R -= D, quotient bit 1; else quotient bit 0.
  - R is DW+1 bits wide to avoid overflow of the shifted remainder.
  - The full 32-bit quotient is accumulated internally.
- Latency: Go sampled at edge 0 → Valid high during the cycle after edge K+1 (33 cycles default). Divide-by-zero: Valid the cycle after edge 1.
- Result rules:
  - D==0: Quotient = all ones (2^QW-1), DivZero=1, Ovf=0.
  - Internal quotient bits above QW-1 nonzero: Quotient = all ones, Ovf=1.
  - Otherwise: Quotient = low QW bits, truncated (floor), no rounding.
- Go handling:
  - Go while Busy=1 is ignored; operands are not re-latched.
  - Go in the FIN cycle is ignored.
  - Go held high continuously starts a new operation on the first IDLE cycle after FIN.
- Output timing: Quotient, DivZero and Ovf change only in the FIN cycle, or at reset. They are stable while Busy=1.
- Go and Reset in the same cycle: Reset wins; nothing is latched.

Decomposition:
- Shared package:
  - State encoding constants (IDLE, RUN, FIN).
  - Defaults for NW, DW, QW, SMAX.
  - ITER = NW+SMAX.
  - Counter width = clog2(ITER+1).
- One sub-module, fx_div_step: combinational single restoring step with inputs (R, next bit, D) and outputs (R', q).
- The top module holds the FSM, operand registers, counter and saturation logic.

Test Plan:
- N=1, D=4, S=15 → after 33 cycles Valid pulse; Quotient=0x002000, DivZero=0, Ovf=0.
- N=3, D=0x00FF, S=8 → Quotient=0x000003; then N=0xFFFF, D=0x00FF, S=8 → 0x010100.
- N=0x1234, D=0 → Valid in the 2nd cycle after Go; Quotient=0xFFFFFF, DivZero=1, Busy low two cycles after Go.
- N=0xFFFF, D=1, S=16 → true quotient 0xFFFF0000 overflows; Quotient=0xFFFFFF, Ovf=1. Shift=31 gives the identical result via clamp.
- Pulse Go with N=7, D=2, S=0; at cycle 10 assert Go with new operands → ignored; result Quotient=0x000003 at cycle 33.
- Start an operation, assert Reset at cycle 12 → next cycle Busy=0, Quotient=0, no Valid. A following Go with N=10, D=3, S=0 → Quotient=0x000003.
